// File: rtl/issue_ctrl_if.sv
// Decode-to-execute issue bus: dual push from decode,
// dual issue toward the two execute pipes, plus redirect flush.
interface issue_ctrl_if #(
  parameter int ENTRY_W = 85
);
  logic               flush;
  logic [1:0]         in_valid;
  logic [ENTRY_W-1:0] in_entry0;
  logic [ENTRY_W-1:0] in_entry1;
  logic               in_ready;
  logic               issue_ready;
  logic               issue0_valid;
  logic [ENTRY_W-1:0] issue0_entry;
  logic               issue1_valid;
  logic [ENTRY_W-1:0] issue1_entry;

  modport master (
    output flush, in_valid, in_entry0, in_entry1, issue_ready,
    input  in_ready, issue0_valid, issue0_entry,
    input  issue1_valid, issue1_entry
  );

  modport slave (
    input  flush, in_valid, in_entry0, in_entry1, issue_ready,
    output in_ready, issue0_valid, issue0_entry,
    output issue1_valid, issue1_entry
  );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: circular queue with pairing rules,
// branch/delay-slot coupling and redirect flush handling.
module issue_ctrl #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int ENTRY_W = 85
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);
  typedef enum logic {
    NORMAL  = 1'b0,
    DS_WAIT = 1'b1
  } state_t;

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH-2);

  logic [ENTRY_W-1:0] r_q [DEPTH];
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W:0]     r_cnt;
  state_t             r_st;
  logic               r_pend;

  logic [ENTRY_W-1:0] w_e0;
  logic [ENTRY_W-1:0] w_e1;
  logic               w_haz;
  logic               w_c0;
  logic               w_c1;
  logic               w_one;
  logic               w_two;
  logic               w_v0;
  logic               w_v1;
  logic [1:0]         w_pop;
  logic [1:0]         w_push;
  logic               w_clr;
  logic               w_to_ds;

  assign w_e0  = r_q[r_rd];
  assign w_e1  = r_q[r_rd + PTR_W'(1)];
  assign w_c0  = |w_e0[4:2];
  assign w_c1  = |w_e1[4:2];
  assign w_one = (r_cnt != '0);
  assign w_two = (r_cnt >= (PTR_W+1)'(2));

  assign w_haz = w_e0[20] & (w_e0[19:15] != 5'd0) &
                 ((w_e1[14:10] == w_e0[19:15]) |
                  (w_e1[9:5]   == w_e0[19:15]));

  always_comb begin
    w_v0 = 1'b0;
    w_v1 = 1'b0;
    if (r_st == DS_WAIT) begin
      w_v0 = w_one;
    end else if (bus.flush) begin
      w_v0 = 1'b0;
    end else if (w_c0) begin
      w_v0 = w_two;
      w_v1 = w_two & ~w_haz;
    end else begin
      w_v0 = w_one;
      w_v1 = w_two & ~w_c1 & ~w_haz &
             ~(w_e0[1] & w_e1[1]) &
             ~(w_e0[0] & w_e1[0]);
    end
  end

  assign w_pop = bus.issue_ready ?
                 ({1'b0, w_v0} + {1'b0, w_v1}) : 2'd0;

  // a pending redirect lands once the delay slot leaves
  assign w_clr = (r_st == NORMAL) ? bus.flush :
                 ((w_pop != 2'd0) & (r_pend | bus.flush));

  assign w_push = (bus.in_ready & ~w_clr) ?
                  ({1'b0, bus.in_valid[0]} +
                   {1'b0, bus.in_valid[1]}) : 2'd0;

  assign w_to_ds = (r_st == NORMAL) & ~bus.flush &
                   (w_pop != 2'd0) & w_c0 & ~w_v1;

  assign bus.in_ready     = (r_cnt <= FULL_LVL);
  assign bus.issue0_valid = w_v0;
  assign bus.issue1_valid = w_v1;
  assign bus.issue0_entry = w_e0;
  assign bus.issue1_entry = w_e1;

  always_ff @(posedge clk) begin
    if (w_push != 2'd0)
      r_q[r_wr] <= bus.in_entry0;
    if (w_push == 2'd2)
      r_q[r_wr + PTR_W'(1)] <= bus.in_entry1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_st   <= NORMAL;
      r_pend <= 1'b0;
    end else if (w_clr) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_st   <= NORMAL;
      r_pend <= 1'b0;
    end else begin
      r_rd  <= r_rd + PTR_W'(w_pop);
      r_wr  <= r_wr + PTR_W'(w_push);
      r_cnt <= r_cnt + (PTR_W+1)'(w_push)
                     - (PTR_W+1)'(w_pop);
      if (r_st == NORMAL) begin
        if (w_to_ds)
          r_st <= DS_WAIT;
      end else if (w_pop != 2'd0) begin
        r_st <= NORMAL;
      end else if (bus.flush) begin
        r_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic
// against a queue-level model of the scheduling rules.
module tb_issue_ctrl;
  localparam int EW = 85;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_ctrl_if #(.ENTRY_W(EW)) bus ();

  issue_ctrl #(
    .DEPTH(8), .PTR_W(3), .ENTRY_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] mq[$];
  bit m_ds;
  bit m_pend;

  logic s_v0, s_v1, s_rdy;
  logic [EW-1:0] s_e0, s_e1;

  function automatic logic [EW-1:0] mk(
    input int pc, input bit wen, input int dst,
    input int rs, input int rt, input bit br,
    input bit j, input bit jr, input bit ls, input bit hl);
    logic [EW-1:0] e;
    e = '0;
    e[84:53] = pc;
    e[52:21] = pc * 7 + 1;
    e[20]    = wen;
    e[19:15] = dst[4:0];
    e[14:10] = rs[4:0];
    e[9:5]   = rt[4:0];
    e[4]     = br;
    e[3]     = j;
    e[2]     = jr;
    e[1]     = ls;
    e[0]     = hl;
    return e;
  endfunction

  function automatic bit is_ctrl(input logic [EW-1:0] e);
    return e[4] | e[3] | e[2];
  endfunction

  function automatic bit raw(input logic [EW-1:0] a,
                             input logic [EW-1:0] b);
    return a[20] && a[19:15] != 0 &&
           (b[14:10] == a[19:15] || b[9:5] == a[19:15]);
  endfunction

  task automatic chk(input string name,
                     input logic [EW-1:0] act,
                     input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_out(input bit fl,
                           output bit v0, output bit v1);
    int n;
    n  = mq.size();
    v0 = 0;
    v1 = 0;
    if (m_ds) begin
      v0 = (n > 0);
    end else if (fl || n == 0) begin
      v0 = 0;
    end else if (is_ctrl(mq[0])) begin
      v0 = (n >= 2);
      v1 = (n >= 2) && !raw(mq[0], mq[1]);
    end else begin
      v0 = 1;
      v1 = (n >= 2) && !is_ctrl(mq[1]) &&
           !raw(mq[0], mq[1]) &&
           !(mq[0][1] && mq[1][1]) &&
           !(mq[0][0] && mq[1][0]);
    end
  endtask

  task automatic step(input bit fl, input logic [1:0] iv,
                      input logic [EW-1:0] a,
                      input logic [EW-1:0] b,
                      input bit rdy);
    bit v0, v1, ir, c0;
    int pops;
    @(negedge clk);
    bus.flush       = fl;
    bus.in_valid    = iv;
    bus.in_entry0   = a;
    bus.in_entry1   = b;
    bus.issue_ready = rdy;
    #1;
    model_out(fl, v0, v1);
    ir = (mq.size() <= 6);
    chk("in_ready", bus.in_ready, ir);
    chk("issue0_valid", bus.issue0_valid, v0);
    chk("issue1_valid", bus.issue1_valid, v1);
    if (v0) chk("issue0_entry", bus.issue0_entry, mq[0]);
    if (v1) chk("issue1_entry", bus.issue1_entry, mq[1]);
    s_v0  = bus.issue0_valid;
    s_v1  = bus.issue1_valid;
    s_rdy = bus.in_ready;
    s_e0  = bus.issue0_entry;
    s_e1  = bus.issue1_entry;
    @(posedge clk);
    pops = rdy ? (int'(v0) + int'(v1)) : 0;
    c0   = (mq.size() > 0) && is_ctrl(mq[0]);
    if (!m_ds) begin
      if (fl) begin
        mq.delete();
      end else begin
        repeat (pops) void'(mq.pop_front());
        if (ir && iv[0]) mq.push_back(a);
        if (ir && iv[1]) mq.push_back(b);
        if (pops == 1 && c0) m_ds = 1;
      end
    end else if (pops > 0) begin
      void'(mq.pop_front());
      m_ds = 0;
      if (m_pend || fl) begin
        mq.delete();
        m_pend = 0;
      end else begin
        if (ir && iv[0]) mq.push_back(a);
        if (ir && iv[1]) mq.push_back(b);
      end
    end else begin
      if (ir && iv[0]) mq.push_back(a);
      if (ir && iv[1]) mq.push_back(b);
      if (fl) m_pend = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 2'b00;
    bus.issue_ready = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_v0", bus.issue0_valid, 0);
    chk("rst_v1", bus.issue1_valid, 0);
    mq.delete();
    m_ds   = 0;
    m_pend = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [EW-1:0] addu3, ori4, raw6, beq, nop;
  logic [EW-1:0] jal, dslot, x1, x2, x3, z;
  logic [EW-1:0] f [8];

  function automatic logic [EW-1:0] rnd_entry(input int pc);
    int k;
    k = $urandom_range(0, 11);
    return mk(pc, bit'($urandom_range(0, 1)),
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), k == 0, k == 1, k == 2,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0);
  endfunction

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 2'b00;
    bus.in_entry0   = '0;
    bus.in_entry1   = '0;
    bus.issue_ready = 1'b1;
    z = '0;

    addu3 = mk(100, 1, 3, 1, 2, 0, 0, 0, 0, 0);
    ori4  = mk(104, 1, 4, 5, 4, 0, 0, 0, 0, 0);
    raw6  = mk(108, 1, 6, 3, 3, 0, 0, 0, 0, 0);
    beq   = mk(200, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    nop   = mk(204, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    jal   = mk(300, 1, 31, 0, 0, 0, 1, 0, 0, 0);
    dslot = mk(304, 1, 8, 31, 0, 0, 0, 0, 0, 0);
    x1    = mk(308, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    x2    = mk(312, 0, 0, 2, 2, 0, 0, 0, 0, 0);
    x3    = mk(316, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      f[i] = mk(400 + 4 * i, 0, 0, i, i, 0, 0, 0, 0, 0);

    do_reset();
    step(0, 2'b00, z, z, 1);
    chk("idle_v0", s_v0, 0);

    // independent pair issues together
    step(0, 2'b11, addu3, ori4, 1);
    step(0, 2'b00, z, z, 1);
    chk("pair_v0", s_v0, 1);
    chk("pair_v1", s_v1, 1);
    chk("pair_e1", s_e1, ori4);
    step(0, 2'b00, z, z, 1);
    chk("pair_empty", s_v0, 0);

    // RAW splits the pair
    step(0, 2'b11, addu3, raw6, 1);
    step(0, 2'b00, z, z, 1);
    chk("raw_a_v1", s_v1, 0);
    step(0, 2'b00, z, z, 1);
    chk("raw_b_v0", s_v0, 1);
    chk("raw_b_e0", s_e0, raw6);

    // branch waits for its delay slot
    step(0, 2'b01, beq, z, 1);
    step(0, 2'b01, nop, z, 1);
    chk("br_wait", s_v0, 0);
    step(0, 2'b00, z, z, 1);
    chk("br_v0", s_v0, 1);
    chk("br_v1", s_v1, 1);

    // jal with hazarding delay slot, flush mid-slot
    step(0, 2'b11, jal, dslot, 1);
    step(0, 2'b00, z, z, 1);
    chk("jal_alone", s_v1, 0);
    chk("jal_e0", s_e0, jal);
    step(1, 2'b11, x1, x2, 0);
    chk("ds_present", s_v0, 1);
    step(0, 2'b01, x3, z, 1);
    chk("ds_e0", s_e0, dslot);
    step(0, 2'b00, z, z, 1);
    chk("ds_cleared", s_v0, 0);

    // fill to 8, then drain across pointer wrap
    for (int i = 0; i < 4; i++)
      step(0, 2'b11, f[2*i], f[2*i+1], 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, z, z, 1);
      chk("drain_rdy", s_rdy, i != 0);
      chk("drain_pc", s_e0[84:53], 32'(400 + 8 * i));
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0] iv;
      iv = ($urandom_range(0, 2) == 0) ? 2'b00 :
           ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b11);
      if (cyc == 1500) do_reset();
      step($urandom_range(0, 9) == 0, iv,
           rnd_entry(1000 + 8 * cyc),
           rnd_entry(1004 + 8 * cyc),
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
